// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the FSM encoding, reset PC, NOP encoding and ECALL halt code.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
    localparam logic [31:0] NOP_INST        = 32'h0000_0013;
    localparam int unsigned ECALL_HALT_CODE = 10;

    // Instruction addresses must be word aligned.
    function automatic logic addr_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: JAL > JALR > taken branch > fall-through.
// Purely combinational (zero latency); no handshake, no backpressure.
// All sums wrap modulo 2^XLEN.
module next_pc_sel
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            branch,
    input  logic            bcond,
    input  logic            is_ecall,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] target,
    output logic            target_misaligned
);

    logic [XLEN-1:0] pc_rel;
    logic [XLEN-1:0] reg_rel;
    logic [XLEN-1:0] seq_pc;

    assign pc_rel  = pc + imm;
    assign reg_rel = (rs1_data + imm) & ~XLEN'(1);
    assign seq_pc  = pc + XLEN'(4);

    always_comb begin
        target = seq_pc;
        // A non-halting ECALL behaves as a NOP regardless of other control bits.
        if (is_ecall) begin
            target = seq_pc;
        end else if (is_jal) begin
            target = pc_rel;
        end else if (is_jalr) begin
            target = reg_rel;
        end else if (branch && bcond) begin
            target = pc_rel;
        end
    end

    assign target_misaligned = addr_misaligned(target[1:0]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fetches over req/ready, holds inst until commit.
// Latency: imem_ready at edge N gives inst_valid in cycle N+1; commit at N gives new PC at N+1.
// Backpressure: request and address held stable while imem_ready is low; inst frozen until commit.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     inst,
    output logic            inst_valid,
    output logic [XLEN-1:0] current_pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            commit,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            branch,
    input  logic            is_ecall,
    input  logic            bcond,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            ecall_halt,
    output logic            is_halted,
    output logic            misaligned
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic            halted_q, halted_d;
    logic            misaligned_q, misaligned_d;

    logic [XLEN-1:0] sel_target;
    logic            sel_misaligned;

    next_pc_sel #(
        .XLEN (XLEN)
    ) u_next_pc_sel (
        .is_jal            (is_jal),
        .is_jalr           (is_jalr),
        .branch            (branch),
        .bcond             (bcond),
        .is_ecall          (is_ecall),
        .pc                (pc_q),
        .imm               (imm),
        .rs1_data          (rs1_data),
        .target            (sel_target),
        .target_misaligned (sel_misaligned)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        halted_d     = halted_q;
        misaligned_d = misaligned_q;

        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    inst_d  = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (commit) begin
                    if (is_ecall && ecall_halt) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else if (sel_misaligned) begin
                        // PC stays on the offending instruction for post-mortem.
                        misaligned_d = 1'b1;
                        state_d      = ST_HALT;
                    end else begin
                        pc_d    = sel_target;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            halted_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            halted_q     <= halted_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign imem_req   = (state_q == ST_FETCH) && !reset;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = (state_q == ST_EXEC);
    assign current_pc = pc_q;
    assign pc_plus4   = pc_q + XLEN'(4);
    assign is_halted  = halted_q;
    assign misaligned = misaligned_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the decode `control_unit`. It owns the architectural PC and issues requests to instruction memory over a ready/valid handshake. It holds the fetched instruction stable for decode/execute. When execute commits, it selects the next PC from the control signals `is_jal`, `is_jalr`, `branch` and `is_ecall`, together with the ALU branch condition. It also detects halt and misaligned-target conditions.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `XLEN`, 32: datapath width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  instruction-memory request valid.
- `imem_addr`  out  XLEN  request address; always equals `current_pc`.
- `imem_ready`  in  1  memory accepts the request and returns data in the same cycle.
- `imem_rdata`  in  32  instruction word; sampled only when `imem_req && imem_ready`.
- `inst`  out  32  latched instruction, driven to decode.
- `inst_valid`  out  1  `inst` and `current_pc` are valid for decode/execute.
- `current_pc`  out  XLEN  PC of `inst`.
- `pc_plus4`  out  XLEN  `current_pc + 4`, used for `pc_to_reg` writeback.
- `commit`  in  1  single-cycle pulse from execute: the instruction is complete.
- `is_jal`, `is_jalr`, `branch`, `is_ecall`  in  1 each  from `control_unit`; sampled at `commit`.
- `bcond`  in  1  ALU branch-condition result.
- `imm`  in  XLEN  sign-extended immediate.
- `rs1_data`  in  XLEN  rs1 operand, used as the JALR base.
- `ecall_halt`  in  1  register x17 equals 10; sampled with `is_ecall`.
- `is_halted`  out  1  halt reached; sticky until reset.
- `misaligned`  out  1  next-PC target not 4-byte aligned; sticky until reset.

## Operation
- FSM states: FETCH, EXEC, HALT. Encoding is in the package.
- **FETCH**
  - `imem_req` = 1 and `imem_addr` = `current_pc`, held stable until `imem_ready`.
  - On `imem_ready`: `inst` ← `imem_rdata`; state → EXEC.
- **EXEC**
  - `inst_valid` = 1 and `imem_req` = 0. `inst` and `current_pc` are frozen until `commit`.
  - On `commit`, next-PC priority:
    - `is_jal`: `current_pc + imm`.
    - else `is_jalr`: `(rs1_data + imm) & ~1`.
    - else `branch && bcond`: `current_pc + imm`.
    - else `pc_plus4`.
  - All sums wrap modulo 2^XLEN; there is no overflow flag.
  - `commit` with `is_ecall && ecall_halt`: PC unchanged; state → HALT; `is_halted` ← 1.
  - `commit` with `is_ecall && !ecall_halt`: the ECALL is treated as a NOP and falls through to `pc_plus4`.
  - Selected target with bits [1:0] ≠ 0: PC unchanged; `misaligned` ← 1; state → HALT.
  - Otherwise: PC ← target; state → FETCH.
- **HALT**
  - Absorbing state. `imem_req` = 0 and `inst_valid` = 0.
  - `commit` is ignored. Only `reset` exits.
- `commit` outside EXEC is ignored. Control inputs are don't-care when `commit` = 0.
- `imem_rdata` outside a FETCH handshake is ignored.

## Timing
- **Reset** (when `reset` = 1 at an edge):
  - PC = `RESET_PC`, state = FETCH, `inst` = 32'h0000_0013 (NOP).
  - `inst_valid`, `is_halted`, `misaligned` = 0.
  - `imem_req` is forced to 0 while `reset` = 1 and rises in the first cycle after release.
- Reset mid-operation overrides every other event in that cycle, including simultaneous `imem_ready` or `commit`.
- Fetch latency: `imem_ready` at edge N → `inst_valid` = 1 from cycle N+1.
  - Minimum loop is 2 cycles per instruction: FETCH, then EXEC with `commit` in the same cycle.
- `commit` at edge N → new `current_pc` and `imem_req` = 1 in cycle N+1.
- `is_halted` and `misaligned` rise in the cycle after the triggering `commit`.
- `imem_ready` may stay low indefinitely; the request and address remain stable throughout.

## Structure
- Shared package `fetch_pkg`:
  - FSM state enum.
  - `RESET_PC` default.
  - NOP encoding 32'h0000_0013.
  - ECALL halt code 10.
- One sub-module, `next_pc_sel`, is purely combinational: control signals, `bcond`, PC, `imm` and `rs1_data` in; target and misaligned flag out.
- The FSM and PC/`inst` registers stay in `fetch_unit`.

## Test plan
- **Reset and straight-line fetch.** Release reset with `imem_ready` tied high and commit three ALU ops → `imem_addr` sequence 0x0, 0x4, 0x8; `inst_valid` one cycle after each handshake.
- **Memory stall.** Hold `imem_ready` low for 5 cycles at PC 0x10 → `imem_req` high and `imem_addr` = 0x10 for all 5 cycles; `inst_valid` = 0 until cycle 7.
- **Branches.** At PC 0x20 with `imm` = -8: `branch` = 1, `bcond` = 1 → next PC 0x18. Same with `bcond` = 0 → next PC 0x24.
- **JALR.** `is_jalr` with `rs1_data` = 0x101, `imm` = 3 → next PC 0x104 (bit 0 cleared). With `rs1_data` = 0x102, `imm` = 0 → `misaligned` = 1, HALT, PC unchanged.
- **ECALL.** `is_ecall` with `ecall_halt` = 1 at PC 0x40 → `is_halted` = 1 next cycle; PC stays 0x40; later `commit` pulses are ignored. With `ecall_halt` = 0 → next PC 0x44.
- **Reset mid-operation.** Assert reset in EXEC in the same cycle as `commit` (JAL target 0x80) → PC = `RESET_PC`, no jump taken, state FETCH, `imem_req` = 0 until reset releases.
